// File: rtl/hazard_stall_ctrl.sv
// Load-use stall / branch flush / ext-stall sequencer for the IF, ID and ID/EXE stages, plus ID operand forwarding selects.
// Optional HAZ_PERF_CNT_EN adds saturating bubble and flush counters.
module hazard_stall_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch_taken,
    input  logic              exe_wreg,
    input  logic              exe_m2reg,
    input  logic [REG_AW-1:0] exe_rn,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_rn,
    input  logic              ext_stall,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idexe_we,
    output logic              idexe_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

    // state    | meaning
    // RUN      | normal issue; a load-use hazard here produces the first bubble
    // LU_STALL | extra bubble cycles for LOAD_LAT>1, cnt counts down the remainder
    typedef enum logic {RUN, LU_STALL} state_t;

    localparam logic [1:0] LAT_REM = 2'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    state_t     state;
    logic [1:0] cnt;
    logic       hz;
    logic       exe_fwd_ok;
    logic       mem_fwd_ok;

    assign hz = exe_wreg & exe_m2reg & (exe_rn != '0) &
                ((id_use_rs & (exe_rn == id_rs)) | (id_use_rt & (exe_rn == id_rt)));

    // A load in EXE has no ALU result worth forwarding; it is covered by the stall.
    assign exe_fwd_ok = exe_wreg & ~exe_m2reg & (exe_rn != '0);
    assign mem_fwd_ok = mem_wreg & (mem_rn != '0);

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idexe_we     = 1'b1;
        idexe_bubble = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        if (!rst_n) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
        end else begin
            if (ext_stall) begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idexe_we = 1'b0;
            end else if (state == LU_STALL || hz) begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idexe_bubble = 1'b1;
            end else if (id_branch_taken) begin
                ifid_flush = 1'b1;
            end

            if (exe_fwd_ok && exe_rn == id_rs)
                fwd_a = 2'b01;
            else if (mem_fwd_ok && mem_rn == id_rs)
                fwd_a = 2'b10;

            if (exe_fwd_ok && exe_rn == id_rt)
                fwd_b = 2'b01;
            else if (mem_fwd_ok && mem_rn == id_rt)
                fwd_b = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else if (!ext_stall) begin
            case (state)
                RUN: begin
                    if (hz && LOAD_LAT > 1) begin
                        state <= LU_STALL;
                        cnt   <= LAT_REM;
                    end
                end
                LU_STALL: begin
                    if (cnt == 2'd0)
                        state <= RUN;
                    else
                        cnt <= cnt - 2'd1;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Outside reset, bubble/flush are already zero while ext_stall freezes the pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (idexe_bubble && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + CNT_ONE;
            if (ifid_flush && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + CNT_ONE;
        end
    end
`endif

endmodule
